mw8080_video_gen: RTL and testbench

MW8080_VIDEO_GEN -- requirements
Module: mw8080_video_gen

---
 rtl/mw8080_video_pkg.sv | 28 ++
 rtl/mw8080_int_ctrl.sv | 36 +++
 rtl/mw8080_video_gen.sv | 103 ++++++++++
 tb/tb_mw8080_video_gen.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mw8080_video_pkg.sv
// Shared timing constants, interrupt vectors and a window helper for the
// 8080-era bitmap video generator.
package mw8080_video_pkg;

  localparam logic [8:0] H_ACT_START = 9'd8;
  localparam logic [8:0] H_ACT_END   = 9'd263;
  localparam logic [8:0] HSYNC_START = 9'd272;
  localparam logic [8:0] HSYNC_END   = 9'd303;
  localparam logic [8:0] FETCH_END   = 9'd256;

  // Vertical sync sits a fixed distance below the last visible line:
  // lines 236..239 with the default 224 visible lines.
  localparam int VSYNC_OFS   = 12;
  localparam int VSYNC_LINES = 4;

  typedef enum logic [7:0] {
    VEC_NONE = 8'h00,
    VEC_RST1 = 8'hCF,
    VEC_RST2 = 8'hD7
  } int_vec_e;

  function automatic logic in_window(input logic [8:0] val,
                                     input logic [8:0] lo,
                                     input logic [8:0] hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/mw8080_int_ctrl.sv
// Interrupt request latch: a new frame event always wins over a pending
// request or a simultaneous acknowledge.
module mw8080_int_ctrl
  import mw8080_video_pkg::*;
(
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ev_mid,
  input  logic       ev_vblank,
  input  logic       int_ack,
  output logic       int_req,
  output logic [7:0] int_vec
);

  int_vec_e vec_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values present before the edge, independent of process ordering.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      int_req <= 1'b0;
      vec_q   <= VEC_NONE;
    end else if (ev_mid) begin
      int_req <= 1'b1;
      vec_q   <= VEC_RST1;
    end else if (ev_vblank) begin
      int_req <= 1'b1;
      vec_q   <= VEC_RST2;
    end else if (int_ack) begin
      int_req <= 1'b0;
    end
  end

  assign int_vec = vec_q;

endmodule

// File: rtl/mw8080_video_gen.sv
// Bitmap video generator: raster counters, byte fetch from video RAM,
// LSB-first pixel shifter, sync/blank generation and frame interrupts.
module mw8080_video_gen
  import mw8080_video_pkg::*;
#(
  parameter int H_TOTAL  = 320,
  parameter int V_TOTAL  = 262,
  parameter int V_ACTIVE = 224,
  parameter int MID_LINE = 96
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ce_pix,
  output logic [12:0] ram_addr,
  output logic        ram_rd,
  input  logic [7:0]  ram_data,
  output logic        video,
  output logic        hsync_n,
  output logic        vsync_n,
  output logic        hblank,
  output logic        vblank,
  output logic        int_req,
  output logic [7:0]  int_vec,
  input  logic        int_ack
);

  localparam logic [8:0] H_LAST   = 9'(H_TOTAL - 1);
  localparam logic [8:0] V_LAST   = 9'(V_TOTAL - 1);
  localparam logic [8:0] V_ACT    = 9'(V_ACTIVE);
  localparam logic [8:0] V_MID    = 9'(MID_LINE);
  localparam logic [8:0] VS_FIRST = 9'(V_ACTIVE + VSYNC_OFS);
  localparam logic [8:0] VS_LAST  = 9'(V_ACTIVE + VSYNC_OFS + VSYNC_LINES - 1);

  logic [8:0] hcount, vcount;
  logic [8:0] h_next, v_next;
  logic [7:0] hold_q, shift_q;
  logic       rd_d;
  logic       fetch, load, act_next, ev_mid, ev_vblank;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    h_next = hcount + 9'd1;
    v_next = vcount;
    if (hcount == H_LAST) begin
      h_next = '0;
      v_next = (vcount == V_LAST) ? '0 : vcount + 9'd1;
    end
  end

  // Decisions use the count present during the ce_pix; registered outputs
  // are computed from the count that ce_pix moves to, so both stay aligned.
  assign fetch     = ce_pix && (hcount[2:0] == 3'd0) && (hcount < FETCH_END) && (vcount < V_ACT);
  assign load      = (hcount[2:0] == 3'd7);
  assign act_next  = in_window(h_next, H_ACT_START, H_ACT_END) && (v_next < V_ACT);
  assign ev_mid    = ce_pix && (hcount == '0) && (vcount == V_MID);
  assign ev_vblank = ce_pix && (hcount == '0) && (vcount == V_ACT);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hcount   <= '0;
      vcount   <= '0;
      // NOTE: the pixel holding and shift registers are cleared on reset so a
      // restarted frame can never display a stale byte.
      hold_q   <= '0;
      shift_q  <= '0;
      rd_d     <= 1'b0;
      ram_rd   <= 1'b0;
      ram_addr <= '0;
      video    <= 1'b0;
      hsync_n  <= 1'b1;
      vsync_n  <= 1'b1;
      hblank   <= 1'b1;
      vblank   <= 1'b0;
    end else begin
      rd_d   <= ram_rd;
      ram_rd <= fetch;
      if (fetch) ram_addr <= {vcount[7:0], hcount[7:3]};
      if (rd_d)  hold_q   <= ram_data;
      if (ce_pix) begin
        hcount  <= h_next;
        vcount  <= v_next;
        shift_q <= load ? hold_q : {1'b0, shift_q[7:1]};
        video   <= act_next && (load ? hold_q[0] : shift_q[1]);
        hblank  <= !in_window(h_next, H_ACT_START, H_ACT_END);
        vblank  <= (v_next >= V_ACT);
        hsync_n <= !in_window(h_next, HSYNC_START, HSYNC_END);
        vsync_n <= !in_window(v_next, VS_FIRST, VS_LAST);
      end
    end
  end

  mw8080_int_ctrl u_int_ctrl (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .ev_mid    (ev_mid),
    .ev_vblank (ev_vblank),
    .int_ack   (int_ack),
    .int_req   (int_req),
    .int_vec   (int_vec)
  );

endmodule

// File: tb/tb_mw8080_video_gen.sv
// Self-checking bench: raster-level behavioural model plus directed pins on
// pixel placement, frame fetch counts, sync widths, interrupts and reset.
module tb_mw8080_video_gen;

  localparam int H_TOT = 320;
  localparam int V_TOT = 32;
  localparam int V_ACT = 16;
  localparam int MID   = 8;

  logic        clk_sys;
  logic        reset;
  logic        ce_pix;
  logic [12:0] ram_addr;
  logic        ram_rd;
  logic [7:0]  ram_data;
  logic        video;
  logic        hsync_n;
  logic        vsync_n;
  logic        hblank;
  logic        vblank;
  logic        int_req;
  logic [7:0]  int_vec;
  logic        int_ack;

  mw8080_video_gen #(
    .H_TOTAL  (H_TOT),
    .V_TOTAL  (V_TOT),
    .V_ACTIVE (V_ACT),
    .MID_LINE (MID)
  ) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .ce_pix   (ce_pix),
    .ram_addr (ram_addr),
    .ram_rd   (ram_rd),
    .ram_data (ram_data),
    .video    (video),
    .hsync_n  (hsync_n),
    .vsync_n  (vsync_n),
    .hblank   (hblank),
    .vblank   (vblank),
    .int_req  (int_req),
    .int_vec  (int_vec),
    .int_ack  (int_ack)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Video RAM: data appears the cycle after the read strobe.
  logic [7:0] mem [0:8191];
  initial ram_data = 8'h00;
  always @(posedge clk_sys) begin
    if (ram_rd) ram_data <= mem[ram_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: raster position and expected output values.
  int          mh, mv, frames;
  logic        model_on;
  logic        e_video, e_hs, e_vs, e_hb, e_vb, e_rd, e_req;
  logic [12:0] e_addr;
  logic [7:0]  e_vec;

  function automatic logic pixel(input int h, input int v);
    int          x;
    logic [12:0] a;
    logic [7:0]  b;
    x = h - 8;
    a = 13'(v * 32 + x / 8);
    b = mem[a];
    return b[x % 8];
  endfunction

  task automatic model_step(input logic ce, input logic ack, input logic rst);
    logic ev_mid, ev_vbl;
    ev_mid = 1'b0;
    ev_vbl = 1'b0;
    e_rd   = 1'b0;
    if (rst) begin
      mh = 0; mv = 0;
      e_addr = '0; e_video = 1'b0; e_hs = 1'b1; e_vs = 1'b1;
      e_hb = 1'b1; e_vb = 1'b0; e_req = 1'b0; e_vec = 8'h00;
    end else begin
      if (ce) begin
        if (mh % 8 == 0 && mh < 256 && mv < V_ACT) begin
          e_rd   = 1'b1;
          e_addr = 13'(mv * 32 + mh / 8);
        end
        ev_mid = (mh == 0 && mv == MID);
        ev_vbl = (mh == 0 && mv == V_ACT);
        if (mh == H_TOT - 1) begin
          mh = 0;
          if (mv == V_TOT - 1) begin mv = 0; frames++; end
          else mv++;
        end else begin
          mh++;
        end
        e_hb    = !(mh >= 8 && mh <= 263);
        e_vb    = (mv >= V_ACT);
        e_hs    = !(mh >= 272 && mh <= 303);
        e_vs    = !(mv >= V_ACT + 12 && mv <= V_ACT + 15);
        e_video = (!e_hb && !e_vb) ? pixel(mh, mv) : 1'b0;
      end
      if (ev_mid) begin
        e_req = 1'b1; e_vec = 8'hCF;
      end else if (ev_vbl) begin
        e_req = 1'b1; e_vec = 8'hD7;
      end else if (ack) begin
        e_req = 1'b0;
      end
    end
  endtask

  task automatic tick(input logic ce, input logic ack, input logic rst);
    ce_pix  = ce;
    int_ack = ack;
    reset   = rst;
    @(posedge clk_sys);
    model_step(ce, ack, rst);
    model_on = 1'b1;
    #1;
  endtask

  // Compare process: every output against the model on every cycle.
  always @(negedge clk_sys) begin
    if (model_on) begin
      check("video",    32'(video),    32'(e_video));
      check("hsync_n",  32'(hsync_n),  32'(e_hs));
      check("vsync_n",  32'(vsync_n),  32'(e_vs));
      check("hblank",   32'(hblank),   32'(e_hb));
      check("vblank",   32'(vblank),   32'(e_vb));
      check("ram_rd",   32'(ram_rd),   32'(e_rd));
      check("ram_addr", 32'(ram_addr), 32'(e_addr));
      check("int_req",  32'(int_req),  32'(e_req));
      check("int_vec",  32'(int_vec),  32'(e_vec));
    end
  end

  logic       ce, ack, last_ce, forced_done, vbl_done, forced_now, vbl_now;
  int         vid_ones, vid_first_h, rd_cnt, rd_vb, hs_cnt, vs_lines, n_ce;
  logic [7:0] a5_bits;

  initial begin
    model_on = 1'b0;
    frames = 0; mh = 0; mv = 0;
    reset = 1'b1; ce_pix = 1'b0; int_ack = 1'b0;
    for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    mem[0]          = 8'h01;
    mem[10 * 32 + 3] = 8'hA5;

    // Reset held with ce_pix toggling.
    for (int i = 0; i < 4; i++) tick(i[0], 1'b0, 1'b1);
    check("rst_video",   32'(video),    32'd0);
    check("rst_hsync_n", 32'(hsync_n),  32'd1);
    check("rst_vsync_n", 32'(vsync_n),  32'd1);
    check("rst_hblank",  32'(hblank),   32'd1);
    check("rst_vblank",  32'(vblank),   32'd0);
    check("rst_ram_rd",  32'(ram_rd),   32'd0);
    check("rst_int_vec", 32'(int_vec),  32'h00);

    // Frame 1: ce_pix every second cycle, no acknowledges.
    vid_ones = 0; vid_first_h = -1; rd_cnt = 0; rd_vb = 0; hs_cnt = 0; vs_lines = 0;
    a5_bits = 8'h00;
    ce = 1'b0;
    for (int c = 0; c < 40000 && frames == 0; c++) begin
      ce = !ce;
      tick(ce, 1'b0, 1'b0);
      if (ram_rd) rd_cnt++;
      if (ram_rd && vblank) rd_vb++;
      if (ce && !hsync_n) hs_cnt++;
      if (ce && mh == 0 && !vsync_n) vs_lines++;
      if (mv == 0 && frames == 0 && video) begin
        if (vid_ones == 0) vid_first_h = mh;
        vid_ones++;
      end
      if (mv == 10 && mh >= 32 && mh <= 39) a5_bits[mh - 32] = video;
      if (ce && mh == 0 && mv == MID) check("req_before_mid", 32'(int_req), 32'd0);
      if (ce && mh == 1 && mv == MID) begin
        check("mid_req", 32'(int_req), 32'd1);
        check("mid_vec", 32'(int_vec), 32'hCF);
      end
      if (ce && mh == 1 && mv == V_ACT) begin
        check("vbl_req", 32'(int_req), 32'd1);
        check("vbl_vec", 32'(int_vec), 32'hD7);
      end
    end
    check("frame1_done",      32'(frames),      32'd1);
    check("line0_ones",       32'(vid_ones),    32'd2);
    check("line0_first_h",    32'(vid_first_h), 32'd8);
    check("line10_bits",      32'(a5_bits),     32'hA5);
    check("rd_per_frame",     32'(rd_cnt),      32'(V_ACT * 32));
    check("rd_in_vblank",     32'(rd_vb),       32'd0);
    check("hsync_ce_frame",   32'(hs_cnt),      32'(32 * V_TOT));
    check("vsync_lines",      32'(vs_lines),    32'd4);

    // Frame 2: random ce_pix spacing, random and directed acknowledges.
    last_ce = 1'b0; forced_done = 1'b0; vbl_done = 1'b0;
    for (int c = 0; c < 40000 && !(frames == 1 && mv == 22 && mh == 100); c++) begin
      ce = !last_ce && ($urandom_range(0, 1) == 1);
      ack = 1'b0; forced_now = 1'b0; vbl_now = 1'b0;
      if (!forced_done && mv == 2 && mh >= 100) begin
        ack = 1'b1; forced_now = 1'b1;
      end else if (ce && !vbl_done && mh == 0 && mv == V_ACT) begin
        check("pre_vbl_req", 32'(int_req), 32'd1);
        check("pre_vbl_vec", 32'(int_vec), 32'hCF);
        ack = 1'b1; vbl_now = 1'b1;
      end else if ((mv < MID - 1 || mv > V_ACT + 1) && $urandom_range(0, 199) == 0) begin
        ack = 1'b1;
      end
      tick(ce, ack, 1'b0);
      last_ce = ce;
      if (forced_now) begin
        forced_done = 1'b1;
        check("ack_clears",    32'(int_req), 32'd0);
        check("ack_vec_holds", 32'(int_vec), 32'hD7);
      end
      if (vbl_now) begin
        vbl_done = 1'b1;
        check("ack_vs_event_req", 32'(int_req), 32'd1);
        check("ack_vs_event_vec", 32'(int_vec), 32'hD7);
      end
    end
    check("reached_reset_point", 32'(frames == 1 && mv == 22 && mh == 100), 32'd1);

    // Mid-frame reset: takes effect on the next edge regardless of ce_pix.
    tick(!last_ce, 1'b0, 1'b1);
    check("mrst_video",    32'(video),    32'd0);
    check("mrst_hsync_n",  32'(hsync_n),  32'd1);
    check("mrst_vsync_n",  32'(vsync_n),  32'd1);
    check("mrst_hblank",   32'(hblank),   32'd1);
    check("mrst_vblank",   32'(vblank),   32'd0);
    check("mrst_ram_rd",   32'(ram_rd),   32'd0);
    check("mrst_ram_addr", 32'(ram_addr), 32'd0);
    check("mrst_int_req",  32'(int_req),  32'd0);
    check("mrst_int_vec",  32'(int_vec),  32'h00);
    tick(1'b0, 1'b0, 1'b1);

    // Restart at hcount 0, vcount 0: first ce_pix fetches byte 0 of line 0.
    tick(1'b1, 1'b0, 1'b0);
    check("restart_rd",   32'(ram_rd),   32'd1);
    check("restart_addr", 32'(ram_addr), 32'd0);
    n_ce = 1; ce = 1'b1;
    for (int c = 0; c < 100 && hblank; c++) begin
      ce = !ce;
      tick(ce, 1'b0, 1'b0);
      if (ce) n_ce++;
    end
    check("ce_to_active", 32'(n_ce), 32'd8);
    for (int c = 0; c < 1300; c++) begin
      ce = !ce;
      tick(ce, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
